// File: rtl/seven_seg_pattern_decoder.sv
// Recovers the hex nibble shown on a 7-segment pattern. The pattern is synchronised,
// must hold steady for STABLE_CYCLES cycles, and is then decoded, reported blank or flagged illegal.
module seven_seg_pattern_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [6:0] i_Segments,
  output logic [3:0] o_Nibble,
  output logic       o_Valid,
  output logic       o_Error,
  output logic       o_Blank,
  output logic [6:0] o_Pattern
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  localparam logic [0:0] SETTLING = 1'b0;
  localparam logic [0:0] STABLE   = 1'b1;

  logic [6:0]       seg_norm;
  logic [6:0]       sync_meta;
  logic [6:0]       sync_out;
  logic [6:0]       ref_pat;
  logic [CNT_W-1:0] cnt;
  logic [0:0]       state;
  logic             tbl_hit;
  logic [3:0]       tbl_nibble;

  // Normalise to active-high before the synchroniser so every later stage sees lit = 1.
  assign seg_norm = ACTIVE_LOW ? ~i_Segments : i_Segments;

  always_comb begin
    tbl_hit    = 1'b1;
    tbl_nibble = 4'h0;
    case (ref_pat)
      7'h3F: tbl_nibble = 4'h0;
      7'h06: tbl_nibble = 4'h1;
      7'h5B: tbl_nibble = 4'h2;
      7'h4F: tbl_nibble = 4'h3;
      7'h66: tbl_nibble = 4'h4;
      7'h6D: tbl_nibble = 4'h5;
      7'h7D: tbl_nibble = 4'h6;
      7'h07: tbl_nibble = 4'h7;
      7'h7F: tbl_nibble = 4'h8;
      7'h6F: tbl_nibble = 4'h9;
      7'h77: tbl_nibble = 4'hA;
      7'h7C: tbl_nibble = 4'hB;
      7'h39: tbl_nibble = 4'hC;
      7'h5E: tbl_nibble = 4'hD;
      7'h79: tbl_nibble = 4'hE;
      7'h71: tbl_nibble = 4'hF;
      default: tbl_hit = 1'b0;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sync_meta <= 7'h00;
      sync_out  <= 7'h00;
      ref_pat   <= 7'h00;
      cnt       <= '0;
      state     <= SETTLING;
      o_Nibble  <= 4'h0;
      o_Valid   <= 1'b0;
      o_Error   <= 1'b0;
      o_Blank   <= 1'b0;
      o_Pattern <= 7'h00;
    end else begin
      sync_meta <= seg_norm;
      sync_out  <= sync_meta;
      o_Valid   <= 1'b0;
      o_Error   <= 1'b0;
      case (state)
        SETTLING: begin
          if (sync_out != ref_pat) begin
            ref_pat <= sync_out;
            cnt     <= '0;
          end else if (cnt == CNT_LAST) begin
            // Pattern has held long enough: decode exactly once, then wait for a change.
            state     <= STABLE;
            cnt       <= '0;
            o_Pattern <= ref_pat;
            if (tbl_hit) begin
              o_Nibble <= tbl_nibble;
              o_Valid  <= 1'b1;
              o_Blank  <= 1'b0;
            end else if (ref_pat == 7'h00) begin
              o_Blank <= 1'b1;
            end else begin
              o_Error <= 1'b1;
              o_Blank <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (sync_out != ref_pat) begin
            ref_pat <= sync_out;
            cnt     <= '0;
            state   <= SETTLING;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_pattern_decoder.sv
// Scoreboard bench for seven_seg_pattern_decoder: expected decode events are queued
// as patterns are driven and retired when o_Valid/o_Error pulse.
module tb_seven_seg_pattern_decoder;

  localparam int STABLE_CYCLES = 4;
  localparam bit ACTIVE_LOW    = 1'b1;

  typedef struct {
    bit         err;
    logic [3:0] nib;
    logic [6:0] pat;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg_pins;
  logic [3:0] nibble;
  logic       valid;
  logic       error;
  logic       blank;
  logic [6:0] pattern;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [6:0] prev_val;
  exp_t       sb[$];

  logic [6:0] seg_table [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seven_seg_pattern_decoder #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .ACTIVE_LOW   (ACTIVE_LOW)
  ) dut (
    .i_Clk     (clk),
    .i_Rst_L   (rst_n),
    .i_Segments(seg_pins),
    .o_Nibble  (nibble),
    .o_Valid   (valid),
    .o_Error   (error),
    .o_Blank   (blank),
    .o_Pattern (pattern)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  function automatic int lookup(input logic [6:0] v);
    for (int i = 0; i < 16; i++)
      if (seg_table[i] == v) return i;
    return -1;
  endfunction

  // Pins change mid-cycle; the edge after the drive is the first to sample them,
  // and the decode shows up STABLE_CYCLES+2 edges after that.
  task automatic applyStimulus(input logic [6:0] val, input int hold);
    exp_t e;
    int   idx;
    seg_pins = ACTIVE_LOW ? ~val : val;
    if (val != prev_val && hold >= STABLE_CYCLES + 1 && val != 7'h00) begin
      idx   = lookup(val);
      e.err = (idx < 0);
      e.nib = (idx < 0) ? 4'h0 : 4'(idx);
      e.pat = val;
      e.cyc = cyc + 1 + STABLE_CYCLES + 2;
      sb.push_back(e);
    end
    prev_val = val;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      checkOutput("missed_pulse", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    if (valid && error) checkOutput("valid_and_error", 32'd1, 32'd0);
    if (valid || error) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_pulse", {30'd0, error, valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("pulse_kind_err", 32'(error), 32'(e.err));
        checkOutput("pulse_latency", cyc, e.cyc);
        checkOutput("pulse_pattern", 32'(pattern), 32'(e.pat));
        if (!e.err) checkOutput("pulse_nibble", 32'(nibble), 32'(e.nib));
      end
    end
  end

  initial begin
    exp_t e;
    rst_n    = 1'b0;
    seg_pins = ACTIVE_LOW ? 7'h7F : 7'h00;
    prev_val = 7'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_nibble", 32'(nibble), 32'h0);
    checkOutput("reset_valid", 32'(valid), 32'h0);
    checkOutput("reset_error", 32'(error), 32'h0);
    checkOutput("reset_blank", 32'(blank), 32'h0);
    checkOutput("reset_pattern", 32'(pattern), 32'h0);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("idle_blank", 32'(blank), 32'h1);

    $display("[TB] single pattern 2");
    applyStimulus(7'h5B, 12);
    checkOutput("t1_nibble", 32'(nibble), 32'h2);
    checkOutput("t1_pattern", 32'(pattern), 32'h5B);

    $display("[TB] table sweep");
    for (int i = 0; i < 16; i++) applyStimulus(seg_table[i], 10);
    checkOutput("t2_nibble", 32'(nibble), 32'hF);

    $display("[TB] glitch restart");
    applyStimulus(7'h3F, 10);
    applyStimulus(7'h06, 2);
    applyStimulus(7'h3F, 12);
    checkOutput("t3_nibble", 32'(nibble), 32'h0);

    $display("[TB] blank then 8");
    applyStimulus(7'h00, 10);
    checkOutput("t4_blank", 32'(blank), 32'h1);
    checkOutput("t4_nibble_held", 32'(nibble), 32'h0);
    checkOutput("t4_pattern", 32'(pattern), 32'h00);
    applyStimulus(7'h7F, 10);
    checkOutput("t4_unblank", 32'(blank), 32'h0);
    checkOutput("t4_nibble", 32'(nibble), 32'h8);

    $display("[TB] illegal pattern");
    applyStimulus(7'h01, 10);
    checkOutput("t5_nibble_held", 32'(nibble), 32'h8);
    checkOutput("t5_pattern", 32'(pattern), 32'h01);
    checkOutput("t5_blank", 32'(blank), 32'h0);

    $display("[TB] reset mid-settle");
    seg_pins = ACTIVE_LOW ? ~7'h66 : 7'h66;
    prev_val = 7'h66;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t6_rst_nibble", 32'(nibble), 32'h0);
    checkOutput("t6_rst_valid", 32'(valid), 32'h0);
    checkOutput("t6_rst_error", 32'(error), 32'h0);
    checkOutput("t6_rst_blank", 32'(blank), 32'h0);
    checkOutput("t6_rst_pattern", 32'(pattern), 32'h0);
    rst_n = 1'b1;
    e.err = 1'b0;
    e.nib = 4'h4;
    e.pat = 7'h66;
    e.cyc = cyc + 1 + STABLE_CYCLES + 2;
    sb.push_back(e);
    repeat (12) @(posedge clk);
    #1;
    checkOutput("t6_nibble", 32'(nibble), 32'h4);
    checkOutput("t6_pattern", 32'(pattern), 32'h66);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("pending_events", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
